// File: rtl/dda_stream_packer.sv
// DDA-out link transmitter: range-checks, saturates and packs per-ray results into
// 38-bit records and streams them as an AXI-stream master through a small elastic buffer.
module dda_stream_packer #(
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 180,
  parameter int DEPTH         = 4
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        dda_valid_in,
  input  logic [10:0] dda_hcount_in,
  input  logic [15:0] dda_lineHeight_in,
  input  logic        dda_wallType_in,
  input  logic [3:0]  dda_mapData_in,
  input  logic [15:0] dda_wallX_in,
  output logic        dda_ready_out,
  input  logic        fifo_tready_in,
  output logic        fifo_tvalid_out,
  output logic [37:0] fifo_tdata_out,
  output logic        fifo_tlast_out,
  output logic        overflow_out,
  output logic        range_err_out,
  output logic        frame_done_out,
  output logic [8:0]  rays_sent_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [10:0]   WIDTH_11  = 11'(SCREEN_WIDTH);
  localparam logic [10:0]   LAST_COL  = 11'(SCREEN_WIDTH - 1);
  localparam logic [15:0]   HEIGHT_16 = 16'(SCREEN_HEIGHT);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

  // Each entry carries its tlast flag in bit 38 above the 38-bit record.
  logic [38:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  logic        in_range;
  logic        full;
  logic        push;
  logic        pop;
  logic [7:0]  line_height;
  logic [38:0] entry;
  logic [38:0] head;

  always_comb begin
    in_range    = (dda_hcount_in < WIDTH_11);
    full        = (count_reg == DEPTH_C);
    push        = dda_valid_in && in_range && !full;
    pop         = (count_reg != '0) && fifo_tready_in;
    line_height = (dda_lineHeight_in >= HEIGHT_16) ? HEIGHT_16[7:0] : dda_lineHeight_in[7:0];
    entry       = {(dda_hcount_in == LAST_COL), dda_hcount_in[8:0], line_height,
                   dda_wallType_in, dda_mapData_in, dda_wallX_in};
  end

  always_ff @(posedge pixel_clk_in) begin
    if (push) begin
      mem[wr_ptr_reg] <= entry;
    end
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      overflow_out   <= 1'b0;
      range_err_out  <= 1'b0;
      frame_done_out <= 1'b0;
      rays_sent_out  <= '0;
    end else begin
      if (dda_valid_in && !in_range) begin
        range_err_out <= 1'b1;
      end
      if (dda_valid_in && in_range && full) begin
        overflow_out <= 1'b1;
      end
      frame_done_out <= pop && head[38];
      if (pop) begin
        rays_sent_out <= head[38] ? 9'd0 : rays_sent_out + 1'b1;
      end
    end
  end

  // Empty buffer presents zeros so nothing stale or uninitialised leaks out.
  assign head            = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
  assign fifo_tvalid_out = (count_reg != '0);
  assign fifo_tdata_out  = head[37:0];
  assign fifo_tlast_out  = head[38];
  assign dda_ready_out   = !full;

endmodule

// File: tb/tb_dda_stream_packer.sv
// Directed plus randomized bench for dda_stream_packer, checked against a queue-based
// reference model of the packing, buffering and frame-counting rules.
module tb_dda_stream_packer;

  localparam int W  = 320;
  localparam int H  = 180;
  localparam int D  = 4;

  logic        pixel_clk_in = 1'b0;
  logic        rst_in;
  logic        dda_valid_in;
  logic [10:0] dda_hcount_in;
  logic [15:0] dda_lineHeight_in;
  logic        dda_wallType_in;
  logic [3:0]  dda_mapData_in;
  logic [15:0] dda_wallX_in;
  logic        dda_ready_out;
  logic        fifo_tready_in;
  logic        fifo_tvalid_out;
  logic [37:0] fifo_tdata_out;
  logic        fifo_tlast_out;
  logic        overflow_out;
  logic        range_err_out;
  logic        frame_done_out;
  logic [8:0]  rays_sent_out;

  dda_stream_packer #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .DEPTH(D)) dut (
    .pixel_clk_in      (pixel_clk_in),
    .rst_in            (rst_in),
    .dda_valid_in      (dda_valid_in),
    .dda_hcount_in     (dda_hcount_in),
    .dda_lineHeight_in (dda_lineHeight_in),
    .dda_wallType_in   (dda_wallType_in),
    .dda_mapData_in    (dda_mapData_in),
    .dda_wallX_in      (dda_wallX_in),
    .dda_ready_out     (dda_ready_out),
    .fifo_tready_in    (fifo_tready_in),
    .fifo_tvalid_out   (fifo_tvalid_out),
    .fifo_tdata_out    (fifo_tdata_out),
    .fifo_tlast_out    (fifo_tlast_out),
    .overflow_out      (overflow_out),
    .range_err_out     (range_err_out),
    .frame_done_out    (frame_done_out),
    .rays_sent_out     (rays_sent_out)
  );

  always #5 pixel_clk_in = ~pixel_clk_in;

  int checks = 0;
  int failures = 0;
  int beats = 0;
  int tlast_beats = 0;
  int fd_seen = 0;

  // Reference model state.
  logic [38:0] q[$];
  bit m_ovf, m_rng, m_fd;
  int m_rays;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Record value from plain arithmetic on the field rules; bit 38 is the tlast flag.
  function automatic logic [38:0] pack(int hc, int lh, int wt, int md, int wx);
    longint v;
    int h8;
    h8 = (lh >= H) ? H : (lh % 256);
    v = longint'(hc % 512) * 64'd536870912 + longint'(h8) * 2097152
        + longint'(wt) * 1048576 + longint'(md) * 65536 + longint'(wx);
    if (hc == W - 1) v = v + 64'd274877906944;
    return v[38:0];
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_rng = 0; m_fd = 0; m_rays = 0;
  endtask

  task automatic check_all();
    chk("tvalid", fifo_tvalid_out, q.size() != 0);
    if (q.size() != 0) begin
      chk("tdata", fifo_tdata_out, q[0][37:0]);
      chk("tlast", fifo_tlast_out, q[0][38]);
    end
    chk("ready", dda_ready_out, q.size() < D);
    chk("overflow", overflow_out, m_ovf);
    chk("range_err", range_err_out, m_rng);
    chk("frame_done", frame_done_out, m_fd);
    chk("rays_sent", rays_sent_out, m_rays);
  endtask

  task automatic model_update();
    int sz;
    bit p, inr, pu;
    logic [38:0] front;
    sz = q.size();
    p = (sz != 0) && fifo_tready_in;
    inr = int'(dda_hcount_in) < W;
    pu = dda_valid_in && inr && (sz < D);
    if (dda_valid_in && !inr) m_rng = 1;
    if (dda_valid_in && inr && sz == D) m_ovf = 1;
    m_fd = 0;
    if (p) begin
      front = q.pop_front();
      m_fd = front[38];
      m_rays = front[38] ? 0 : (m_rays + 1) % 512;
    end
    if (pu) q.push_back(pack(int'(dda_hcount_in), int'(dda_lineHeight_in), int'(dda_wallType_in),
                             int'(dda_mapData_in), int'(dda_wallX_in)));
  endtask

  // Inputs are driven at posedge+1; outputs are checked at the negedge before the next edge.
  task automatic step();
    @(negedge pixel_clk_in);
    check_all();
    if (fifo_tvalid_out && fifo_tready_in) begin
      beats++;
      if (fifo_tlast_out) tlast_beats++;
    end
    if (frame_done_out) fd_seen++;
    model_update();
    @(posedge pixel_clk_in);
    #1;
  endtask

  task automatic drive(input bit v, input int hc, input int lh, input int wt, input int md, input int wx);
    dda_valid_in      = v;
    dda_hcount_in     = 11'(hc);
    dda_lineHeight_in = 16'(lh);
    dda_wallType_in   = 1'(wt);
    dda_mapData_in    = 4'(md);
    dda_wallX_in      = 16'(wx);
  endtask

  initial begin
    int b0, f0;
    rst_in = 1'b0;
    fifo_tready_in = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();

    // Reset values.
    #12;
    check_all();
    chk("rst_tdata", fifo_tdata_out, 38'd0);
    chk("rst_tlast", fifo_tlast_out, 1'b0);
    #10 rst_in = 1'b1;
    @(posedge pixel_clk_in); #1;

    // Single ray.
    fifo_tready_in = 1'b1;
    drive(1, 5, 60, 1, 1, 16'h1234);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("single_tvalid", fifo_tvalid_out, 1'b1);
    chk("single_tdata", fifo_tdata_out, {9'd5, 8'd60, 1'b1, 4'd1, 16'h1234});
    chk("single_tlast", fifo_tlast_out, 1'b0);
    step();
    chk("single_rays", rays_sent_out, 9'd1);

    // Line-height saturation.
    drive(1, 1, 400, 0, 2, 7); step();
    chk("lh400", fifo_tdata_out[28:21], 8'd180);
    drive(1, 2, 180, 0, 2, 7); step();
    chk("lh180", fifo_tdata_out[28:21], 8'd180);
    drive(1, 3, 179, 0, 2, 7); step();
    chk("lh179", fifo_tdata_out[28:21], 8'd179);
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step();

    // Full frame back-to-back.
    b0 = beats; f0 = fd_seen; tlast_beats = 0;
    for (int c = 0; c < W; c++) begin
      drive(1, c, $urandom_range(0, 400), $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 65535));
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step();
    chk("frame_beats", beats - b0, W);
    chk("frame_tlast", tlast_beats, 1);
    chk("frame_done_cnt", fd_seen - f0, 1);
    chk("frame_rays_zero", rays_sent_out, 9'd0);

    // Out-of-range column.
    drive(1, 320, 50, 0, 3, 9); step();
    drive(0, 0, 0, 0, 0, 0);
    chk("range_err_set", range_err_out, 1'b1);
    chk("range_no_ovf", overflow_out, 1'b0);
    chk("range_no_beat", fifo_tvalid_out, 1'b0);
    step();

    // Overflow under stall.
    fifo_tready_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 10 + i, 20 + i, i % 2, i, 16'hA000 + i);
      step();
      if (i == 3) chk("ready_low_full", dda_ready_out, 1'b0);
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("ovf_set", overflow_out, 1'b1);
    repeat (3) step();
    b0 = beats;
    fifo_tready_in = 1'b1;
    repeat (6) step();
    chk("ovf_drain_beats", beats - b0, 4);

    // Asynchronous reset mid-stream.
    fifo_tready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 30 + i, 90, 1, 5, 16'h0BEE);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    #2 rst_in = 1'b0;
    #1;
    model_reset();
    chk("rst_tvalid_now", fifo_tvalid_out, 1'b0);
    chk("rst_ovf_now", overflow_out, 1'b0);
    @(negedge pixel_clk_in);
    check_all();
    @(posedge pixel_clk_in);
    #3 rst_in = 1'b1;
    @(posedge pixel_clk_in); #1;
    drive(1, 7, 33, 0, 4, 16'h5555); step();
    drive(0, 0, 0, 0, 0, 0);
    chk("post_rst_tvalid", fifo_tvalid_out, 1'b1);
    chk("post_rst_tdata", fifo_tdata_out, {9'd7, 8'd33, 1'b0, 4'd4, 16'h5555});
    chk("post_rst_range", range_err_out, 1'b0);
    fifo_tready_in = 1'b1;
    step();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      int r, hc;
      r = $urandom_range(0, 19);
      if (r == 0) hc = $urandom_range(320, 2047);
      else if (r < 3) hc = W - 1;
      else hc = $urandom_range(0, W - 1);
      drive($urandom_range(0, 3) != 0, hc, ($urandom_range(0, 1) != 0) ? $urandom_range(0, 255) : $urandom_range(0, 65535),
            $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 65535));
      fifo_tready_in = ($urandom_range(0, 2) != 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    fifo_tready_in = 1'b1;
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dda_stream_packer.md
# dda_stream_packer

Transmitter side of the DDA-out FIFO link. Takes per-ray results from the DDA pipeline, range-checks and saturates them, packs them into the 38-bit record the flattening stage consumes, and drives it out as an AXI-stream master through a small elastic buffer. It flags end-of-frame (tlast on the last screen column), reports drops, and counts the rays sent per frame.

## Interface
Parameters:
- SCREEN_WIDTH, 320: ray columns per frame; the last column is SCREEN_WIDTH-1.
- SCREEN_HEIGHT, 180: saturation ceiling for line height; must be ≤255.
- DEPTH, 4: elastic buffer entries; power of two, ≥2.

Ports:
- pixel_clk_in  in  1  sole clock.
- rst_in  in  1  asynchronous, active-low reset.
- dda_valid_in  in  1  one ray result present this cycle.
- dda_hcount_in  in  11  ray column.
- dda_lineHeight_in  in  16  SCREEN_HEIGHT/perpWallDist.
- dda_wallType_in  in  1  0 = X wall hit, 1 = Y wall hit.
- dda_mapData_in  in  4  map cell value.
- dda_wallX_in  in  16  wall hit position.
- dda_ready_out  out  1  buffer has a free entry.
- fifo_tready_in  in  1  FIFO slave ready.
- fifo_tvalid_out  out  1  record valid.
- fifo_tdata_out  out  38  packed record.
- fifo_tlast_out  out  1  record is the last column of the frame.
- overflow_out  out  1  sticky: a valid ray was dropped because the buffer was full.
- range_err_out  out  1  sticky: a ray with hcount ≥ SCREEN_WIDTH was dropped.
- frame_done_out  out  1  one-cycle pulse when a tlast beat is accepted.
- rays_sent_out  out  9  beats accepted in the current frame.

## Operation
- Packing, MSB first: [37:29] hcount[8:0], [28:21] line height, [20] wallType, [19:16] mapData, [15:0] wallX.
- Line height: if dda_lineHeight_in ≥ SCREEN_HEIGHT, send SCREEN_HEIGHT[7:0]; otherwise send dda_lineHeight_in[7:0].
- tlast bit: computed at push time as hcount == SCREEN_WIDTH-1. It is stored with the entry.
- Push happens when dda_valid_in && count < DEPTH && hcount < SCREEN_WIDTH.
  - If dda_valid_in && count == DEPTH: drop the ray and set overflow_out. This holds even if a pop occurs in the same cycle.
  - If hcount ≥ SCREEN_WIDTH: drop the ray and set range_err_out. Range is checked before fullness; an out-of-range ray never sets overflow_out.
- Pop happens when fifo_tvalid_out && fifo_tready_in.
- Buffer: circular, with wr_ptr, rd_ptr and count (0..DEPTH). Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle: count is unchanged.
- Buffer state is derived from count:
  - EMPTY (count 0): tvalid low.
  - PARTIAL: tvalid high, dda_ready_out high.
  - FULL (count DEPTH): tvalid high, dda_ready_out low.
  - Transitions: EMPTY→PARTIAL on push; PARTIAL→FULL on push-only reaching DEPTH; FULL→PARTIAL on pop; PARTIAL→EMPTY on pop-only reaching 0.
- Outputs from buffer state:
  - fifo_tvalid_out = (count != 0).
  - fifo_tdata_out and fifo_tlast_out come from the entry at rd_ptr.
  - dda_ready_out = (count < DEPTH).
- Frame counter:
  - rays_sent_out increments on each pop.
  - On a pop with tlast: rays_sent_out goes to 0 and frame_done_out pulses.
  - The counter wraps at 511 with no error.
- Sticky flags clear only on reset.
- Reset (asserted asynchronously, any time including mid-frame): flush the buffer; count, pointers and rays_sent_out go to 0.
  - Reset values: fifo_tvalid_out 0, fifo_tdata_out 0, fifo_tlast_out 0, dda_ready_out 1, overflow_out 0, range_err_out 0, frame_done_out 0, rays_sent_out 0.
  - Data in flight is discarded.

## Timing
- Push to fifo_tvalid_out: 1 cycle when the buffer is empty (the record is visible the edge after push). There is no combinational path from dda_* to fifo_*.
- Sustained throughput is 1 beat/cycle with tready held high.
- AXI rule: while tvalid && !tready, fifo_tdata_out and fifo_tlast_out hold stable. tvalid never deasserts without a pop.
- dda_ready_out, overflow_out and range_err_out are registered-state functions: each updates the edge after the causing event.
- frame_done_out is high exactly the cycle after the tlast pop edge.
- fifo_tready_in may toggle arbitrarily. Order is strictly FIFO.

## Test plan
- Single ray (hcount 5, lineHeight 60, wallType 1, mapData 1, wallX 0x1234), tready=1 -> one beat next cycle; tdata={9'd5, 8'd60, 1, 4'd1, 16'h1234}; tlast=0; rays_sent_out=1.
- lineHeight 400 and 180 -> field [28:21]=180 for both; lineHeight 179 -> 179.
- Full frame, hcount 0..319 back-to-back, tready=1 -> 320 beats in order; tlast only on hcount 319; frame_done_out pulses once; rays_sent_out returns to 0.
- tready=0 and 6 valid rays pushed (DEPTH 4) -> first 4 buffered; dda_ready_out low after the 4th; rays 5 and 6 dropped; overflow_out=1. Raising tready then yields exactly 4 beats, with tdata stable throughout the stall.
- hcount 320 with valid -> no beat; range_err_out=1; overflow_out stays 0; count unchanged.
- Reset asserted mid-stream with 3 entries buffered and tready=0 -> tvalid falls to 0 immediately; after release, a new ray emerges one cycle after push; sticky flags are 0.
